// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e     : encoding of the 3-bit md_op field
//   mdu_state_e : sequencer states
//   MultCyclesDef / DivCyclesDef : default busy durations
//   is_muldiv() : true for operations that occupy the unit for several cycles
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMulRun = 2'd1,
    StDivRun = 2'd2
  } mdu_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;
  localparam int unsigned CntW          = 16;

  function automatic logic is_muldiv(logic [2:0] op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MIPS-style multiply/divide datapath.
// Ports:
//   i_md_op    : operation code (md_op_e)
//   i_src_a    : rs operand (dividend / multiplicand)
//   i_src_b    : rt operand (divisor / multiplier)
//   o_result   : {HI, LO}; product for MULT(U), {remainder, quotient} for DIV(U)
//   o_div_zero : DIV/DIVU with a zero divisor
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_b_zero;
  logic        [31:0] w_b_safe;
  logic               w_a_neg;
  logic               w_b_neg;
  logic        [31:0] w_a_mag;
  logic        [31:0] w_b_mag;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic        [31:0] w_q_s;
  logic        [31:0] w_r_s;
  logic        [31:0] w_q_u;
  logic        [31:0] w_r_u;

  assign w_prod_s = $signed({{32{i_src_a[31]}}, i_src_a}) * $signed({{32{i_src_b[31]}}, i_src_b});
  assign w_prod_u = {32'd0, i_src_a} * {32'd0, i_src_b};

  // A zero divisor is replaced by 1 so the dividers never see /0; the result is discarded anyway.
  assign w_b_zero = (i_src_b == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : i_src_b;

  // Signed divide on magnitudes. 0x80000000 has magnitude 0x80000000 as an unsigned value,
  // so 0x80000000 / -1 yields quotient 0x80000000 after re-negation, remainder 0.
  assign w_a_neg = i_src_a[31];
  assign w_b_neg = i_src_b[31];
  assign w_a_mag = w_a_neg ? (~i_src_a + 32'd1) : i_src_a;
  assign w_b_mag = w_b_neg ? (~i_src_b + 32'd1) : w_b_safe;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q_s   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_q_u = i_src_a / w_b_safe;
  assign w_r_u = i_src_a % w_b_safe;

  always_comb begin
    o_result   = 64'd0;
    o_div_zero = 1'b0;
    case (i_md_op)
      MdMult:  o_result = w_prod_s;
      MdMultu: o_result = w_prod_u;
      MdDiv: begin
        o_result   = {w_r_s, w_q_s};
        o_div_zero = w_b_zero;
      end
      MdDivu: begin
        o_result   = {w_r_u, w_q_u};
        o_div_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer with HI/LO registers.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_start      : E-stage MD instruction valid
//   i_md_op      : operation code (md_op_e)
//   i_src_a/b    : forwarded rs/rt values
//   i_flush      : exception/interrupt this cycle, cancels an E-stage start
//   i_d_is_md    : D-stage instruction touches the MDU
//   o_busy       : multi-cycle operation in progress
//   o_stall_req  : stall request to the hazard unit
//   o_hi / o_lo  : architectural HI/LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  input  logic        i_d_is_md,
  output logic        o_busy,
  output logic        o_stall_req,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  mdu_state_e       r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [31:0]      r_pend_hi, w_pend_hi_d;
  logic [31:0]      r_pend_lo, w_pend_lo_d;
  logic             r_pend_dz, w_pend_dz_d;
  logic [31:0]      r_hi, w_hi_d;
  logic [31:0]      r_lo, w_lo_d;

  logic [63:0]      w_result;
  logic             w_div_zero;
  logic             w_accept;

  mdu_arith u_arith (
    .i_md_op    (i_md_op),
    .i_src_a    (i_src_a),
    .i_src_b    (i_src_b),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  assign w_accept = i_start & ~i_flush & (r_state == StIdle);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_pend_hi_d = r_pend_hi;
    w_pend_lo_d = r_pend_lo;
    w_pend_dz_d = r_pend_dz;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          case (i_md_op)
            MdMult, MdMultu: begin
              w_state_d   = StMulRun;
              w_cnt_d     = CntW'(MULT_CYCLES - 1);
              w_pend_hi_d = w_result[63:32];
              w_pend_lo_d = w_result[31:0];
              w_pend_dz_d = 1'b0;
            end
            MdDiv, MdDivu: begin
              w_state_d   = StDivRun;
              w_cnt_d     = CntW'(DIV_CYCLES - 1);
              w_pend_hi_d = w_result[63:32];
              w_pend_lo_d = w_result[31:0];
              w_pend_dz_d = w_div_zero;
            end
            MdMthi:  w_hi_d = i_src_a;
            MdMtlo:  w_lo_d = i_src_a;
            default: ;
          endcase
        end
      end
      StMulRun, StDivRun: begin
        // Flush is deliberately ignored here: the owning instruction has already committed.
        if (r_cnt == '0) begin
          w_state_d = StIdle;
          if (!r_pend_dz) begin
            w_hi_d = r_pend_hi;
            w_lo_d = r_pend_lo;
          end
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_dz <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_pend_hi <= w_pend_hi_d;
      r_pend_lo <= w_pend_lo_d;
      r_pend_dz <= w_pend_dz_d;
      r_hi      <= w_hi_d;
      r_lo      <= w_lo_d;
    end
  end

  assign o_busy      = (r_state != StIdle);
  // Reset has priority, so no stall is requested while it is asserted.
  assign o_stall_req = ~reset & i_d_is_md &
                       (o_busy | (i_start & ~i_flush & is_muldiv(i_md_op)));
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  E-stage MD instruction valid this cycle.
REQ-006 md_op  input  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 src_a  input  32  forwarded rs value.
REQ-008 src_b  input  32  forwarded rt value.
REQ-009 flush  input  1  exception or interrupt taken this cycle; cancels the E-stage start.
REQ-010 d_is_md  input  1  D-stage instruction is MULT/DIV/MTHI/MTLO/MFHI/MFLO.
REQ-011 busy  output  1  operation in progress.
REQ-012 stall_req  output  1  stall request to the hazard unit.
REQ-013 hi  output  32  HI register, feeds MFHI.
REQ-014 lo  output  32  LO register, feeds MFLO.

Function
REQ-015 The block SHALL implement states IDLE, MUL_RUN and DIV_RUN, plus a down-counter cnt.
REQ-016 Accepted start = start & !flush & (state==IDLE); all other starts SHALL be ignored.
REQ-017 On an accepted MULT/MULTU/DIV/DIVU at edge T0:
- go to MUL_RUN or DIV_RUN;
- load cnt with MULT_CYCLES-1 or DIV_CYCLES-1;
- latch the 64-bit result into pending registers.
REQ-018 busy SHALL be 1 for exactly N cycles after T0, where N = MULT_CYCLES or DIV_CYCLES.
REQ-019 At edge T0+N the block SHALL write pending HI/LO to hi/lo, return to IDLE and drop busy.
REQ-020 hi/lo SHALL change only at completion, on an accepted MTHI/MTLO, or on reset.
REQ-021 MTHI/MTLO (accepted) SHALL write src_a into hi/lo at the next edge, with no busy cycle.
REQ-022 MULT SHALL be a signed 32x32->64 multiply; MULTU unsigned; HI = result[63:32], LO = result[31:0].
REQ-023 DIV/DIVU divide rules:
- LO = quotient, HI = remainder;
- signed quotient truncates toward zero;
- remainder takes the sign of the dividend.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-025 For divide by zero, the block SHALL run the full DIV_CYCLES and then leave hi/lo unchanged.
REQ-026 stall_req = d_is_md & (busy | (start & !flush & md_op is MULT/MULTU/DIV/DIVU)).
REQ-027 A flush while busy SHALL NOT abort the operation, since that instruction has already committed.
REQ-028 A start asserted while busy SHALL be ignored; the bench flags it as a protocol error.

Reset
REQ-029 Reset SHALL take priority over all other inputs in the same cycle.
REQ-030 Reset values: state=IDLE, cnt=0, pending=0, hi=0, lo=0, busy=0, stall_req=0.
REQ-031 A reset during MUL_RUN/DIV_RUN SHALL discard the pending result.

Structure
REQ-032 md_op encodings, state encodings and MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared definitions header.
REQ-033 Arithmetic SHALL be a combinational sub-module mdu_arith: (md_op, src_a, src_b) -> 64-bit result plus div_zero flag.
REQ-034 Sequencing, counter and HI/LO registers SHALL stay in mdu_ctrl.

Verification
REQ-035 MULT a=0xFFFFFFFE, b=3:
- busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
- stall_req high during busy while d_is_md=1.
REQ-036 DIVU a=7, b=2:
- busy for 10 cycles, then lo=3, hi=1.
- DIV a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIV a=5, b=0 after MTHI 0x1234 and MTLO 0x5678:
- hi=0x1234 and lo=0x5678 after 10 cycles;
- busy falls on schedule.
REQ-038 start with flush=1 (MULT) -> busy stays 0 and hi/lo unchanged; flush at cycle 2 of a DIV -> result still written at T0+10.
REQ-039 Reset at cycle 3 of MULTU -> next cycle busy=0 and hi=lo=0; a following MTLO 0xA5 -> lo=0xA5 one edge later.
